if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the five-stage pipeline. It holds the program counter, drives the combinational-read instruction memory (`IM_read`, `IM_addr`, `IM_out`), and captures each fetched word into the IF/ID pipeline register. It accepts stall requests from the hazard unit and PC redirects (branch/jump) from EX. Its outputs feed the decode stage.

## Interface
- `ADDR_W`, 14: IM word-address width. Must equal the `ImAddr` width used by IM.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset. Must be word aligned.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-low (reset when `rst`==0 at a rising edge of `clk`).
- `stall` in 1: hazard-unit request to hold PC and IF/ID.
- `redirect` in 1: EX requests a PC change; kills the in-flight fetch.
- `redirect_pc` in 32: target PC, valid when `redirect`==1.
- `IM_read` out 1: read enable to IM.
- `IM_addr` out ADDR_W: word address to IM, equal to `pc[ADDR_W+1:2]`.
- `IM_out` in 32: instruction word from IM. IM reads combinationally, so it is valid in the same cycle as `IM_addr`.
- `if_id_pc` out 32: PC of the instruction held in IF/ID.
- `if_id_inst` out 32: instruction held in IF/ID.
- `if_id_valid` out 1: IF/ID holds a real instruction; 0 means bubble.

## Operation
- State:
  - `pc` (32-bit) register.
  - IF/ID register {`if_id_pc`, `if_id_inst`, `if_id_valid`}.
- Combinational outputs:
  - `IM_addr = pc[ADDR_W+1:2]`.
  - `IM_read = rst & ~stall & ~redirect`.
- Per rising edge, priority in order (highest first):
  1. Reset (`rst`==0): `pc`<=`RESET_PC`, `if_id_pc`<=0, `if_id_inst`<=0, `if_id_valid`<=0.
  2. `redirect`==1, regardless of `stall`: `pc`<=`redirect_pc` (see Configuration for the low two bits), `if_id_valid`<=0, `if_id_inst`<=0, `if_id_pc`<=0.
  3. `stall`==1: `pc`, `if_id_pc`, `if_id_inst` and `if_id_valid` all hold.
  4. Otherwise: `if_id_inst`<=`IM_out`, `if_id_pc`<=`pc`, `if_id_valid`<=1, `pc`<=`pc`+4.
- Arithmetic:
  - `pc`+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - IM aliases any PC above 4·2^ADDR_W through truncation of `IM_addr`; no range check is performed.
- While stalled, `if_id_inst` holds its captured copy and does not track `IM_out`.
- The stage itself generates no other state and no exceptions.

## Timing
- Reset values: `IM_read`=0 while `rst`==0, `IM_addr`=`RESET_PC[ADDR_W+1:2]` after the reset edge, `if_id_pc`=0, `if_id_inst`=0, `if_id_valid`=0.
- Fetch latency: one cycle. The word at `pc` appears on `if_id_inst` the cycle after `IM_addr` presents it.
- Throughput: one instruction per cycle when neither `stall` nor `redirect` is asserted.
- Redirect penalty: exactly one bubble.
  - Redirect at edge N: `if_id_valid`=0 after edge N.
  - The target instruction appears, valid, after edge N+1 (if not stalled at N+1).
- Simultaneous `stall` and `redirect`: redirect wins. Stall applies from the following cycle, with `pc` already equal to the target.
- Reset deasserted mid-stream: the first fetch is `RESET_PC` in the cycle after `rst` returns to 1.
- Reset takes effect only at a rising edge; an `rst` pulse between edges has no effect.

## Configuration
- `IF_ALIGN_CHECK_EN` defined:
  - Adds output `if_id_misalign` (out, 1 bit, reset 0).
  - A redirect loads `redirect_pc` unmodified.
  - The fetch from a PC with `pc[1:0]!=0` is captured with `if_id_misalign`=1 and `if_id_valid`=1. Subsequent sequential PCs keep the misalignment.
  - `if_id_misalign` is cleared together with `if_id_valid` on redirect and reset, and holds on stall.
- `IF_ALIGN_CHECK_EN` undefined:
  - The port is absent.
  - A redirect loads `{redirect_pc[31:2], 2'b00}`, so `pc` is always word aligned.

## Test plan
- Reset then free-run, with IM preloaded so that word k = 32'hA000_0000+k:
  - After reset release, `if_id_inst` = A000_0000, A000_0001, A000_0002 on consecutive cycles.
  - `if_id_pc` = 0, 4, 8.
  - `if_id_valid`=1 from the first capture.
- `stall` high for 3 cycles while `if_id_pc`=8:
  - `if_id_pc`/`if_id_inst` hold at 8 / A000_0002 and `IM_read`=0 for those 3 cycles.
  - `if_id_pc`=12 follows on the first unstalled edge.
- `redirect`=1 with `redirect_pc`=32'h40, asserted together with `stall`=1:
  - One bubble (`if_id_valid`=0).
  - Next cycle `if_id_pc`=0x40, `if_id_inst`=A000_0010.
- Mid-stream `rst`=0 for one edge:
  - All IF/ID outputs return to 0 and `if_id_valid`=0.
  - Fetch restarts at `RESET_PC`.
- Wrap-around: redirect to 32'hFFFF_FFFC.
  - Next sequential `if_id_pc` is 0.
  - `IM_addr` equals `{ADDR_W{1'b1}}`, then 0.
- Redirect to 32'h42:
  - With `IF_ALIGN_CHECK_EN`: `if_id_pc`=0x42, `if_id_misalign`=1.
  - Without: `if_id_pc`=0x40.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Bus between the instruction-fetch stage and its neighbours: hazard/EX
// control in, instruction-memory port, and the IF/ID register out.
// Optional feature macro: IF_ALIGN_CHECK_EN adds if_id_misalign.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 14
);
  // Control from hazard unit and EX
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  // Instruction memory port (combinational read)
  logic              IM_read;
  logic [ADDR_W-1:0] IM_addr;
  logic [31:0]       IM_out;
  // IF/ID pipeline register
  logic [31:0]       if_id_pc;
  logic [31:0]       if_id_inst;
  logic              if_id_valid;
`ifdef IF_ALIGN_CHECK_EN
  logic              if_id_misalign;
`endif

  // The fetch stage drives the IM request and the IF/ID register
  modport master (
    input  stall, redirect, redirect_pc, IM_out,
    output IM_read, IM_addr, if_id_pc, if_id_inst, if_id_valid
`ifdef IF_ALIGN_CHECK_EN
    , output if_id_misalign
`endif
  );

  // Surrounding pipeline: hazard unit, EX, IM and decode
  modport slave (
    output stall, redirect, redirect_pc, IM_out,
    input  IM_read, IM_addr, if_id_pc, if_id_inst, if_id_valid
`ifdef IF_ALIGN_CHECK_EN
    , input if_id_misalign
`endif
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, combinational IM request and
// the IF/ID pipeline register. Redirect beats stall; both beat nothing but
// reset. Reset is synchronous, active-low.
// Optional feature macro: IF_ALIGN_CHECK_EN (unaligned redirect targets are
// kept and flagged on if_id_misalign instead of being forced to a word).
module if_fetch_stage #(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  if_fetch_stage_if.master bus
);

  logic [31:0] pc;
  logic [31:0] redirect_target;

  // Redirect target: raw when misalignment is tracked, word-aligned otherwise
  always_comb begin
`ifdef IF_ALIGN_CHECK_EN
    redirect_target = bus.redirect_pc;
`else
    redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
  end

  // IM request: address follows pc; no read while reset, stalled or redirected
  assign bus.IM_addr = pc[ADDR_W+1:2];
  assign bus.IM_read = rst & ~bus.stall & ~bus.redirect;

  // PC and IF/ID update: reset > redirect > stall > sequential fetch
  // NOTE: non-blocking assignments keep every register reading the
  // pre-edge values of the others, so pc and if_id_pc stay one apart.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc              <= RESET_PC;
      bus.if_id_pc    <= '0;
      bus.if_id_inst  <= '0;
      bus.if_id_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      bus.if_id_misalign <= 1'b0;
`endif
    end else if (bus.redirect) begin
      // The in-flight fetch is killed and becomes the single bubble
      pc              <= redirect_target;
      bus.if_id_pc    <= '0;
      bus.if_id_inst  <= '0;
      bus.if_id_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      bus.if_id_misalign <= 1'b0;
`endif
    end else if (!bus.stall) begin
      // Stall simply skips this branch, so everything holds
      pc              <= pc + 32'd4;
      bus.if_id_pc    <= pc;
      bus.if_id_inst  <= bus.IM_out;
      bus.if_id_valid <= 1'b1;
`ifdef IF_ALIGN_CHECK_EN
      bus.if_id_misalign <= (pc[1:0] != 2'b00);
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios from the fetch
// stage's behaviour plus a randomized run against a cycle-level model.
module tb_if_fetch_stage;

  localparam int          ADDR_W   = 14;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  if_fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  if_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word k holds A000_0000 + k
  logic [31:0] imem [0:(1<<ADDR_W)-1];
  assign bus.IM_out = imem[bus.IM_addr];

  logic got_mis;
`ifdef IF_ALIGN_CHECK_EN
  assign got_mis = bus.if_id_misalign;
`else
  assign got_mis = 1'b0;
`endif

  // Reference model state
  logic [31:0] m_pc, m_ipc, m_inst;
  logic        m_valid, m_mis;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 + ((a >> 2) % (32'd1 << ADDR_W));
  endfunction

  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] rpc);
    rst             = r;
    bus.stall       = s;
    bus.redirect    = d;
    bus.redirect_pc = rpc;
    #1;
  endtask

  // Advance the model by one edge using the currently driven inputs, then clock
  task automatic tick();
    if (!rst) begin
      m_pc = RESET_PC; m_ipc = 0; m_inst = 0; m_valid = 0; m_mis = 0;
    end else if (bus.redirect) begin
`ifdef IF_ALIGN_CHECK_EN
      m_pc = bus.redirect_pc;
`else
      m_pc = {bus.redirect_pc[31:2], 2'b00};
`endif
      m_ipc = 0; m_inst = 0; m_valid = 0; m_mis = 0;
    end else if (!bus.stall) begin
      m_ipc   = m_pc;
      m_inst  = word_at(m_pc);
      m_valid = 1;
      m_mis   = (m_pc[1:0] != 0);
      m_pc    = m_pc + 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    checks++;
    if (bus.IM_read !== 1'b0) begin
      errors++; $display("FAIL reset_im_read got=%b exp=0", bus.IM_read);
    end
    tick(); tick();
    checks++;
    if ({bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, got_mis} !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_ifid got pc=%h inst=%h v=%b mis=%b exp all 0",
                         bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, got_mis);
    end
    checks++;
    if (bus.IM_addr !== RESET_PC[ADDR_W+1:2]) begin
      errors++; $display("FAIL reset_im_addr got=%h exp=%h", bus.IM_addr, RESET_PC[ADDR_W+1:2]);
    end
  endtask

  task automatic test_free_run();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.if_id_pc, bus.if_id_inst, bus.if_id_valid} !== {32'(4*i), 32'hA000_0000 + 32'(i), 1'b1}) begin
        errors++; $display("FAIL free_run[%0d] got pc=%h inst=%h v=%b exp pc=%h inst=%h v=1",
                           i, bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, 4*i, 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_stall();
    drive(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.IM_read !== 1'b0) begin
        errors++; $display("FAIL stall_im_read[%0d] got=%b exp=0", i, bus.IM_read);
      end
      tick();
      checks++;
      if ({bus.if_id_pc, bus.if_id_inst, bus.if_id_valid} !== {32'd8, 32'hA000_0002, 1'b1}) begin
        errors++; $display("FAIL stall_hold[%0d] got pc=%h inst=%h v=%b exp pc=8 inst=a0000002 v=1",
                           i, bus.if_id_pc, bus.if_id_inst, bus.if_id_valid);
      end
    end
    drive(1, 0, 0, 0);
    tick();
    checks++;
    if ({bus.if_id_pc, bus.if_id_inst} !== {32'd12, 32'hA000_0003}) begin
      errors++; $display("FAIL stall_release got pc=%h inst=%h exp pc=c inst=a0000003",
                         bus.if_id_pc, bus.if_id_inst);
    end
  endtask

  task automatic test_redirect_stall();
    drive(1, 1, 1, 32'h40);
    checks++;
    if (bus.IM_read !== 1'b0) begin
      errors++; $display("FAIL redirect_im_read got=%b exp=0", bus.IM_read);
    end
    tick();
    checks++;
    if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_inst} !== {1'b0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL redirect_bubble got v=%b pc=%h inst=%h exp v=0 pc=0 inst=0",
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_inst);
    end
    drive(1, 0, 0, 0);
    tick();
    checks++;
    if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_inst} !== {1'b1, 32'h40, 32'hA000_0010}) begin
      errors++; $display("FAIL redirect_target got v=%b pc=%h inst=%h exp v=1 pc=40 inst=a0000010",
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_inst);
    end
  endtask

  task automatic test_mid_reset();
    drive(0, 0, 0, 0);
    tick();
    checks++;
    if ({bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, bus.IM_read} !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset got pc=%h inst=%h v=%b rd=%b exp all 0",
                         bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, bus.IM_read);
    end
    drive(1, 0, 0, 0);
    checks++;
    if (bus.IM_addr !== RESET_PC[ADDR_W+1:2]) begin
      errors++; $display("FAIL mid_reset_addr got=%h exp=%h", bus.IM_addr, RESET_PC[ADDR_W+1:2]);
    end
    tick();
    checks++;
    if ({bus.if_id_pc, bus.if_id_inst, bus.if_id_valid} !== {RESET_PC, word_at(RESET_PC), 1'b1}) begin
      errors++; $display("FAIL mid_reset_restart got pc=%h inst=%h v=%b exp pc=%h inst=%h v=1",
                         bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, RESET_PC, word_at(RESET_PC));
    end
  endtask

  task automatic test_wrap();
    drive(1, 0, 1, 32'hFFFF_FFFC);
    tick();
    checks++;
    if (bus.IM_addr !== {ADDR_W{1'b1}}) begin
      errors++; $display("FAIL wrap_addr_top got=%h exp=%h", bus.IM_addr, {ADDR_W{1'b1}});
    end
    drive(1, 0, 0, 0);
    tick();
    checks++;
    if ({bus.if_id_pc, bus.if_id_inst, bus.IM_addr} !== {32'hFFFF_FFFC, 32'hA000_3FFF, {ADDR_W{1'b0}}}) begin
      errors++; $display("FAIL wrap_last got pc=%h inst=%h addr=%h exp pc=fffffffc inst=a0003fff addr=0",
                         bus.if_id_pc, bus.if_id_inst, bus.IM_addr);
    end
    tick();
    checks++;
    if ({bus.if_id_pc, bus.if_id_inst} !== {32'h0, 32'hA000_0000}) begin
      errors++; $display("FAIL wrap_zero got pc=%h inst=%h exp pc=0 inst=a0000000",
                         bus.if_id_pc, bus.if_id_inst);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_mis;
`ifdef IF_ALIGN_CHECK_EN
    exp_pc = 32'h42; exp_mis = 1'b1;
`else
    exp_pc = 32'h40; exp_mis = 1'b0;
`endif
    drive(1, 0, 1, 32'h42);
    tick();
    drive(1, 0, 0, 0);
    tick();
    checks++;
    if ({bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, got_mis} !== {exp_pc, 32'hA000_0010, 1'b1, exp_mis}) begin
      errors++; $display("FAIL misalign got pc=%h inst=%h v=%b mis=%b exp pc=%h inst=a0000010 v=1 mis=%b",
                         bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, got_mis, exp_pc, exp_mis);
    end
    tick();
    checks++;
    if ({bus.if_id_pc, got_mis} !== {exp_pc + 32'd4, exp_mis}) begin
      errors++; $display("FAIL misalign_next got pc=%h mis=%b exp pc=%h mis=%b",
                         bus.if_id_pc, got_mis, exp_pc + 32'd4, exp_mis);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), $urandom);
      checks++;
      if ({bus.IM_read, bus.IM_addr} !== {rst & ~bus.stall & ~bus.redirect, m_pc[ADDR_W+1:2]}) begin
        errors++; $display("FAIL random_im[%0d] got rd=%b addr=%h exp rd=%b addr=%h", i,
                           bus.IM_read, bus.IM_addr, rst & ~bus.stall & ~bus.redirect, m_pc[ADDR_W+1:2]);
      end
      tick();
      checks++;
      if ({bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, got_mis} !== {m_ipc, m_inst, m_valid, m_mis}) begin
        errors++; $display("FAIL random_ifid[%0d] got pc=%h inst=%h v=%b mis=%b exp pc=%h inst=%h v=%b mis=%b",
                           i, bus.if_id_pc, bus.if_id_inst, bus.if_id_valid, got_mis,
                           m_ipc, m_inst, m_valid, m_mis);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < (1 << ADDR_W); k++) imem[k] = 32'hA000_0000 + 32'(k);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_mid_reset();
    test_wrap();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
